// File: rtl/aes_block_feeder_pkg.sv
// aes_feeder_pkg
//   Shared definitions for the AES block feeder slice.
//   - feeder_state_e : FILL / START / WAIT / OUT controller states
//   - BLOCK_BYTES    : bytes per 128-bit AES block
//   - PAD_FULL       : PKCS#7 pad byte used for a whole extra pad block
package aes_feeder_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } feeder_state_e;

  localparam int         BLOCK_BYTES = 16;
  localparam logic [7:0] PAD_FULL    = 8'h10;

endpackage

// File: rtl/aes_block_feeder_if.sv
// aes_block_feeder_if
//   Bundles the byte-input stream, the AES core handshake and the ciphertext
//   output stream of the feeder.
//   modport master : feeder side (drives in_ready, aes_*, out_*, err)
//   modport slave  : environment side (byte source, AES core, block sink)
interface aes_block_feeder_if;

  logic [127:0] key_in;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;

  logic [127:0] aes_plaintext;
  logic [127:0] aes_key;
  logic         aes_start;
  logic         aes_ready;
  logic [127:0] aes_cipher;

  logic [127:0] out_block;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;

  logic         err;

  modport master (
    input  key_in, in_data, in_valid, in_last,
    input  aes_ready, aes_cipher,
    input  out_ready,
    output in_ready,
    output aes_plaintext, aes_key, aes_start,
    output out_block, out_valid, out_last,
    output err
  );

  modport slave (
    output key_in, in_data, in_valid, in_last,
    output aes_ready, aes_cipher,
    output out_ready,
    input  in_ready,
    input  aes_plaintext, aes_key, aes_start,
    input  out_block, out_valid, out_last,
    input  err
  );

endinterface

// File: rtl/aes_block_feeder_pkcs7_pad.sv
// pkcs7_pad
//   Combinational PKCS#7 padding of a partially filled 128-bit block.
//   Ports:
//     i_block : block with bytes 0..i_count-1 valid (byte 0 in the MSBs)
//     i_count : number of valid bytes, 1..16
//     o_block : i_block with bytes i_count..15 replaced by (16 - i_count);
//               a full block (i_count = 16) passes through unchanged
module pkcs7_pad
  import aes_feeder_pkg::*;
(
  input  logic [127:0] i_block,
  input  logic [4:0]   i_count,
  output logic [127:0] o_block
);

  logic [7:0] w_padVal;

  always_comb begin
    w_padVal = 8'(BLOCK_BYTES) - {3'b000, i_count};
    o_block  = i_block;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (5'(k) >= i_count) begin
        o_block[127 - 8*k -: 8] = w_padVal;
      end
    end
  end

endmodule

// File: rtl/aes_block_feeder.sv
// aes_block_feeder
//   Packs a byte stream into 128-bit blocks (first byte in the MSBs), applies
//   PKCS#7 padding to the final block, runs each block through the AES core
//   and presents the ciphertext on a valid/ready output.
//   Ports:
//     clk     : rising-edge clock
//     reset_n : asynchronous active-low reset
//     bus     : byte input, AES core handshake, ciphertext output, err flag
//   Parameter:
//     TIMEOUT : WAIT cycles without aes_ready before aborting with err
module aes_block_feeder
  import aes_feeder_pkg::*;
#(
  parameter int TIMEOUT = 31
) (
  input logic                clk,
  input logic                reset_n,
  aes_block_feeder_if.master bus
);

  localparam int              CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST_WAIT  = CW'(TIMEOUT - 1);
  localparam logic [4:0]      FULL_COUNT = 5'(BLOCK_BYTES);
  localparam logic [127:0]    PAD_BLOCK  = {BLOCK_BYTES{PAD_FULL}};

  feeder_state_e r_state;
  logic [4:0]    r_byteCnt;
  logic [CW-1:0] r_waitCnt;
  logic          r_padPending;
  logic          r_msgActive;
  logic          r_lastBlk;
  logic          r_inReady;
  logic          r_start;
  logic          r_outValid;
  logic          r_outLast;
  logic          r_err;
  logic [127:0]  r_plaintext;
  logic [127:0]  r_key;
  logic [127:0]  r_outBlock;

  logic          w_accept;
  logic [4:0]    w_count;
  logic [127:0]  w_withByte;
  logic [127:0]  w_padded;

  assign w_accept = (r_state == FILL) && bus.in_valid;
  assign w_count  = r_byteCnt + 5'd1;

  // Current block with the incoming byte dropped into its slot; the byte
  // counter is at most 15 while filling.
  always_comb begin
    w_withByte = r_plaintext;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (r_byteCnt == 5'(k)) begin
        w_withByte[127 - 8*k -: 8] = bus.in_data;
      end
    end
  end

  pkcs7_pad u_pad (
    .i_block (w_withByte),
    .i_count (w_count),
    .o_block (w_padded)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= FILL;
      r_byteCnt    <= '0;
      r_waitCnt    <= '0;
      r_padPending <= 1'b0;
      r_msgActive  <= 1'b0;
      r_lastBlk    <= 1'b0;
      r_inReady    <= 1'b1;
      r_start      <= 1'b0;
      r_outValid   <= 1'b0;
      r_outLast    <= 1'b0;
      r_err        <= 1'b0;
      r_plaintext  <= '0;
      r_key        <= '0;
      r_outBlock   <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_accept) begin
            // The key belongs to the message, so it is taken only once.
            if (!r_msgActive) begin
              r_key       <= bus.key_in;
              r_msgActive <= 1'b1;
            end
            if (bus.in_last || (w_count == FULL_COUNT)) begin
              // A message ending on a block boundary still owes a pad block.
              r_plaintext  <= bus.in_last ? w_padded : w_withByte;
              r_lastBlk    <= bus.in_last;
              r_padPending <= bus.in_last && (w_count == FULL_COUNT);
              r_byteCnt    <= '0;
              r_inReady    <= 1'b0;
              r_start      <= 1'b1;
              r_state      <= START;
            end else begin
              r_plaintext <= w_withByte;
              r_byteCnt   <= w_count;
            end
          end
        end
        START: begin
          r_waitCnt <= '0;
          r_state   <= WAIT;
        end
        WAIT: begin
          // A ready arriving on the final allowed cycle still counts.
          if (bus.aes_ready) begin
            r_outBlock <= bus.aes_cipher;
            r_outValid <= 1'b1;
            r_outLast  <= r_lastBlk && !r_padPending;
            r_state    <= OUT;
          end else if (r_waitCnt == LAST_WAIT) begin
            r_err        <= 1'b1;
            r_padPending <= 1'b0;
            r_lastBlk    <= 1'b0;
            r_msgActive  <= 1'b0;
            r_byteCnt    <= '0;
            r_inReady    <= 1'b1;
            r_state      <= FILL;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_outLast  <= 1'b0;
            if (r_padPending) begin
              r_plaintext  <= PAD_BLOCK;
              r_padPending <= 1'b0;
              r_start      <= 1'b1;
              r_state      <= START;
            end else begin
              r_msgActive <= r_msgActive && !r_lastBlk;
              r_lastBlk   <= 1'b0;
              r_inReady   <= 1'b1;
              r_state     <= FILL;
            end
          end
        end
        default: begin
          r_inReady <= 1'b1;
          r_state   <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_inReady;
  assign bus.aes_plaintext = r_plaintext;
  assign bus.aes_key       = r_key;
  assign bus.aes_start     = r_start;
  assign bus.out_block     = r_outBlock;
  assign bus.out_valid     = r_outValid;
  assign bus.out_last      = r_outLast;
  assign bus.err           = r_err;

endmodule

// File: tb/tb_aes_block_feeder.sv
// tb_aes_block_feeder
//   Directed bench for aes_block_feeder. A stub AES core answers each
//   aes_start after a programmable delay with a known ciphertext (the
//   FIPS-197 vector for its key/plaintext, otherwise plaintext^key^C3..).
module tb_aes_block_feeder;
  import aes_feeder_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  aes_block_feeder_if bus();

  aes_block_feeder #(.TIMEOUT(31)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K4 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [127:0] KV = 128'h000102030405060708090a0b0c0d0e0f;

  function automatic logic [127:0] coreModel(input logic [127:0] pt, input logic [127:0] key);
    if (pt == 128'h00112233445566778899aabbccddeeff && key == KV)
      return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    return pt ^ key ^ 128'hc3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3;
  endfunction

  // Stub core: records every start, answers after stubDelay cycles.
  bit           stubEnable = 1'b1;
  int           stubDelay  = 3;
  bit           lateReq    = 1'b0;
  int           startCount = 0;
  logic [127:0] seenPt[$];
  logic [127:0] seenKey[$];

  initial begin
    bus.aes_ready  = 1'b0;
    bus.aes_cipher = '0;
    forever begin
      @(negedge clk);
      if (lateReq) begin
        lateReq        = 1'b0;
        bus.aes_ready  = 1'b1;
        bus.aes_cipher = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
        @(negedge clk);
        bus.aes_ready  = 1'b0;
        bus.aes_cipher = '0;
      end else if (bus.aes_start === 1'b1) begin
        startCount++;
        seenPt.push_back(bus.aes_plaintext);
        seenKey.push_back(bus.aes_key);
        if (stubEnable) begin
          repeat (stubDelay) @(negedge clk);
          bus.aes_ready  = 1'b1;
          bus.aes_cipher = coreModel(seenPt[$], seenKey[$]);
          @(negedge clk);
          bus.aes_ready  = 1'b0;
          bus.aes_cipher = '0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [127:0] popPt();
    return (seenPt.size() > 0) ? seenPt.pop_front() : 128'hx;
  endfunction

  function automatic logic [127:0] popKey();
    return (seenKey.size() > 0) ? seenKey.pop_front() : 128'hx;
  endfunction

  task automatic sendByte(input logic [7:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("[TB] FAIL in_ready_timeout: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic waitOut(output logic [127:0] blk, output logic lst);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("[TB] FAIL out_valid_timeout: out_valid=%b required 1", bus.out_valid);
    end
    blk = bus.out_block;
    lst = bus.out_last;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 8;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    if (bus.aes_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_aes_start: got %b expected 0", bus.aes_start); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_last: got %b expected 0", bus.out_last); end
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b expected 0", bus.err); end
    if (bus.out_block !== '0) begin errors++; $display("[TB] FAIL rst_out_block: got %h expected 0", bus.out_block); end
    if (bus.aes_plaintext !== '0) begin errors++; $display("[TB] FAIL rst_plaintext: got %h expected 0", bus.aes_plaintext); end
    if (bus.aes_key !== '0) begin errors++; $display("[TB] FAIL rst_key: got %h expected 0", bus.aes_key); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_short_msg();
    logic [127:0] blk, pt, key;
    logic         lst;
    int           base = startCount;
    localparam logic [127:0] EXP = 128'h6162630d0d0d0d0d0d0d0d0d0d0d0d0d;
    bus.key_in = K1;
    sendByte(8'h61, 1'b0);
    sendByte(8'h62, 1'b0);
    sendByte(8'h63, 1'b1);
    checks++;
    if (bus.aes_start !== 1'b1) begin errors++; $display("[TB] FAIL short_start_next: got %b expected 1", bus.aes_start); end
    waitOut(blk, lst);
    pt = popPt(); key = popKey();
    checks += 5;
    if (startCount - base != 1) begin errors++; $display("[TB] FAIL short_starts: got %0d expected 1", startCount - base); end
    if (pt !== EXP) begin errors++; $display("[TB] FAIL short_pt: got %h expected %h", pt, EXP); end
    if (key !== K1) begin errors++; $display("[TB] FAIL short_key: got %h expected %h", key, K1); end
    if (blk !== coreModel(EXP, K1)) begin errors++; $display("[TB] FAIL short_block: got %h expected %h", blk, coreModel(EXP, K1)); end
    if (lst !== 1'b1) begin errors++; $display("[TB] FAIL short_last: got %b expected 1", lst); end
  endtask

  task automatic test_full_plus_pad();
    logic [127:0] blk1, blk2, pt1, pt2;
    logic         lst1, lst2;
    int           base = startCount;
    localparam logic [127:0] EXP1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] EXP2 = 128'h10101010101010101010101010101010;
    bus.key_in = K2;
    for (int i = 0; i < 16; i++) sendByte(8'(i), i == 15);
    waitOut(blk1, lst1);
    checks++;
    if (bus.aes_start !== 1'b1) begin errors++; $display("[TB] FAIL pad_start_next: got %b expected 1", bus.aes_start); end
    waitOut(blk2, lst2);
    pt1 = popPt(); pt2 = popPt();
    void'(popKey()); void'(popKey());
    checks += 7;
    if (startCount - base != 2) begin errors++; $display("[TB] FAIL pad_starts: got %0d expected 2", startCount - base); end
    if (pt1 !== EXP1) begin errors++; $display("[TB] FAIL pad_pt1: got %h expected %h", pt1, EXP1); end
    if (pt2 !== EXP2) begin errors++; $display("[TB] FAIL pad_pt2: got %h expected %h", pt2, EXP2); end
    if (lst1 !== 1'b0) begin errors++; $display("[TB] FAIL pad_last1: got %b expected 0", lst1); end
    if (lst2 !== 1'b1) begin errors++; $display("[TB] FAIL pad_last2: got %b expected 1", lst2); end
    if (blk1 !== coreModel(EXP1, K2)) begin errors++; $display("[TB] FAIL pad_block1: got %h expected %h", blk1, coreModel(EXP1, K2)); end
    if (blk2 !== coreModel(EXP2, K2)) begin errors++; $display("[TB] FAIL pad_block2: got %h expected %h", blk2, coreModel(EXP2, K2)); end
  endtask

  task automatic test_two_blocks_key();
    logic [127:0] blk1, blk2, pt1, pt2, key1, key2;
    logic         lst1, lst2;
    localparam logic [127:0] EXP1 = 128'h202122232425262728292a2b2c2d2e2f;
    localparam logic [127:0] EXP2 = 128'h300f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
    bus.key_in = K3;
    for (int i = 0; i < 16; i++) begin
      sendByte(8'h20 + 8'(i), 1'b0);
      bus.key_in = K4;
    end
    waitOut(blk1, lst1);
    sendByte(8'h30, 1'b1);
    waitOut(blk2, lst2);
    pt1 = popPt(); pt2 = popPt();
    key1 = popKey(); key2 = popKey();
    checks += 8;
    if (pt1 !== EXP1) begin errors++; $display("[TB] FAIL blk2_pt1: got %h expected %h", pt1, EXP1); end
    if (pt2 !== EXP2) begin errors++; $display("[TB] FAIL blk2_pt2: got %h expected %h", pt2, EXP2); end
    if (key1 !== K3) begin errors++; $display("[TB] FAIL blk2_key1: got %h expected %h", key1, K3); end
    if (key2 !== K3) begin errors++; $display("[TB] FAIL blk2_key2: got %h expected %h", key2, K3); end
    if (bus.aes_key !== K3) begin errors++; $display("[TB] FAIL blk2_key_hold: got %h expected %h", bus.aes_key, K3); end
    if (lst1 !== 1'b0) begin errors++; $display("[TB] FAIL blk2_last1: got %b expected 0", lst1); end
    if (lst2 !== 1'b1) begin errors++; $display("[TB] FAIL blk2_last2: got %b expected 1", lst2); end
    if (blk2 !== coreModel(EXP2, K3)) begin errors++; $display("[TB] FAIL blk2_block2: got %h expected %h", blk2, coreModel(EXP2, K3)); end
  endtask

  task automatic test_aes_vector();
    logic [127:0] blk1, blk2, pt1;
    logic         lst1, lst2;
    bus.key_in = KV;
    for (int i = 0; i < 16; i++) sendByte(8'(i * 17), i == 15);
    waitOut(blk1, lst1);
    waitOut(blk2, lst2);
    pt1 = popPt(); void'(popPt());
    void'(popKey()); void'(popKey());
    checks += 4;
    if (pt1 !== 128'h00112233445566778899aabbccddeeff) begin errors++; $display("[TB] FAIL vec_pt: got %h expected 00112233445566778899aabbccddeeff", pt1); end
    if (blk1 !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin errors++; $display("[TB] FAIL vec_block: got %h expected 69c4e0d86a7b0430d8cdb78070b4c55a", blk1); end
    if (lst1 !== 1'b0) begin errors++; $display("[TB] FAIL vec_last1: got %b expected 0", lst1); end
    if (lst2 !== 1'b1) begin errors++; $display("[TB] FAIL vec_last2: got %b expected 1", lst2); end
  endtask

  task automatic test_backpressure();
    logic [127:0] blk;
    logic         lst;
    int           base;
    int           n = 0;
    localparam logic [127:0] EXP = 128'haa0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
    bus.key_in = K1;
    base = startCount;
    sendByte(8'haa, 1'b1);
    while (bus.out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    for (int c = 0; c < 20; c++) begin
      checks += 4;
      if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid c%0d: got %b expected 1", c, bus.out_valid); end
      if (bus.out_block !== coreModel(EXP, K1)) begin errors++; $display("[TB] FAIL bp_block c%0d: got %h expected %h", c, bus.out_block, coreModel(EXP, K1)); end
      if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready c%0d: got %b expected 0", c, bus.in_ready); end
      if (startCount - base != 1) begin errors++; $display("[TB] FAIL bp_starts c%0d: got %0d expected 1", c, startCount - base); end
      @(negedge clk);
    end
    waitOut(blk, lst);
    void'(popPt()); void'(popKey());
    checks += 2;
    if (lst !== 1'b1) begin errors++; $display("[TB] FAIL bp_last: got %b expected 1", lst); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: in_ready got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_ready_at_timeout();
    logic [127:0] blk;
    logic         lst;
    localparam logic [127:0] EXP = 128'h550f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
    bus.key_in = K2;
    stubDelay  = 31;
    sendByte(8'h55, 1'b1);
    waitOut(blk, lst);
    stubDelay  = 3;
    void'(popPt()); void'(popKey());
    checks += 2;
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL edge_err: got %b expected 0", bus.err); end
    if (blk !== coreModel(EXP, K2)) begin errors++; $display("[TB] FAIL edge_block: got %h expected %h", blk, coreModel(EXP, K2)); end
  endtask

  task automatic test_timeout_and_reset();
    logic [127:0] blk;
    logic         lst;
    localparam logic [127:0] EXP = 128'h990f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
    stubEnable = 1'b0;
    bus.key_in = K4;
    sendByte(8'h77, 1'b1);
    repeat (31) @(negedge clk);
    checks += 2;
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_early: got %b expected 0", bus.err); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL to_in_ready_early: got %b expected 0", bus.in_ready); end
    @(negedge clk);
    checks += 2;
    if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL to_err: got %b expected 1", bus.err); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL to_in_ready: got %b expected 1", bus.in_ready); end

    sendByte(8'h88, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    checks += 8;
    if (bus.aes_start !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_start: got %b expected 0", bus.aes_start); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_in_ready: got %b expected 1", bus.in_ready); end
    if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_err: got %b expected 0", bus.err); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", bus.out_valid); end
    if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_last: got %b expected 0", bus.out_last); end
    if (bus.out_block !== '0) begin errors++; $display("[TB] FAIL mid_rst_block: got %h expected 0", bus.out_block); end
    if (bus.aes_plaintext !== '0) begin errors++; $display("[TB] FAIL mid_rst_pt: got %h expected 0", bus.aes_plaintext); end
    if (bus.aes_key !== '0) begin errors++; $display("[TB] FAIL mid_rst_key: got %h expected 0", bus.aes_key); end
    @(negedge clk);
    reset_n = 1'b1;

    lateReq = 1'b1;
    repeat (3) @(negedge clk);
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL late_ready_valid: got %b expected 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL late_ready_in_ready: got %b expected 1", bus.in_ready); end

    seenPt.delete();
    seenKey.delete();
    stubEnable = 1'b1;
    bus.key_in = K1;
    sendByte(8'h99, 1'b1);
    waitOut(blk, lst);
    checks += 2;
    if (blk !== coreModel(EXP, K1)) begin errors++; $display("[TB] FAIL recover_block: got %h expected %h", blk, coreModel(EXP, K1)); end
    if (lst !== 1'b1) begin errors++; $display("[TB] FAIL recover_last: got %b expected 1", lst); end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.key_in    = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    $display("[TB] starting aes_block_feeder bench");
    test_reset();
    test_short_msg();
    test_full_plus_pad();
    test_two_blocks_key();
    test_aes_vector();
    test_backpressure();
    test_ready_at_timeout();
    test_timeout_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
